// File: rtl/shift_right_seq_if.sv
// Handshake and data bundle for the sequential right shifter.
// The master drives the request; the slave (the shifter) returns the result and status.
interface shift_right_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic               arith;
  logic [WIDTH-1:0]   in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   out;
  logic               busy;
  logic               done;

  modport master (output start, arith, in, shamt, input out, busy, done);
  modport slave  (input start, arith, in, shamt, output out, busy, done);
endinterface

// File: rtl/shift_right_seq.sv
// Multi-cycle logical/arithmetic right shifter (IDLE -> SHIFT -> DONE).
// Optional macro SHIFT_RIGHT_FAST_EN: shift 4 bits per cycle while at least 4 remain.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  shift_right_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   work_r;
  logic [WIDTH-1:0]   out_r;
  logic [SHAMT_W-1:0] count_r;
  logic               mode_r;
  logic               busy_r;
  logic               done_r;

  logic [SHAMT_W-1:0] step_s;
  logic [SHAMT_W-1:0] count_next_s;
  logic [WIDTH-1:0]   work_next_s;

  // Step size, next shifted value and remaining count for one SHIFT cycle
  always_comb begin
    step_s = SHAMT_W'(1);
`ifdef SHIFT_RIGHT_FAST_EN
    if (count_r >= SHAMT_W'(4)) begin
      step_s = SHAMT_W'(4);
    end else begin
      step_s = SHAMT_W'(1);
    end
`endif
    work_next_s = work_r;
    if (mode_r) begin
      work_next_s = $signed(work_r) >>> step_s;
    end else begin
      work_next_s = work_r >> step_s;
    end
    count_next_s = count_r - step_s;
  end

  // Control FSM with registered datapath and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      work_r  <= '0;
      out_r   <= '0;
      count_r <= '0;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            work_r  <= bus.in;
            count_r <= bus.shamt;
            mode_r  <= bus.arith;
            busy_r  <= 1'b1;
            if (bus.shamt == SHAMT_W'(0)) begin
              // Zero shift skips SHIFT entirely and publishes the operand as is
              out_r   <= bus.in;
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= SHIFT;
              done_r  <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        SHIFT: begin
          work_r  <= work_next_s;
          count_r <= count_next_s;
          if (count_next_s == SHAMT_W'(0)) begin
            out_r   <= work_next_s;
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_shift_right_seq.sv
// Randomized plus directed bench for shift_right_seq against a transaction-level model.
module tb_shift_right_seq;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_right_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  shift_right_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  // Transaction-level model: an accepted operation finishes lat edges after capture
  bit          m_active = 1'b0;
  int          m_t      = 0;
  int          m_lat    = 0;
  logic [31:0] m_res    = 32'h0;
  logic [31:0] m_out    = 32'h0;
  logic        m_busy   = 1'b0;
  logic        m_done   = 1'b0;

  function automatic int latency(input int k);
`ifdef SHIFT_RIGHT_FAST_EN
    return (k / 4) + (k % 4);
`else
    return k;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_active = 1'b0;
      m_out    = 32'h0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1'b1;
        m_t      = 0;
        m_lat    = latency(int'(bus.shamt));
        if (bus.arith) m_res = $signed(bus.in) >>> bus.shamt;
        else           m_res = bus.in >> bus.shamt;
      end
    end else begin
      m_t++;
    end
    m_busy = 1'b0;
    m_done = 1'b0;
    if (m_active) begin
      if (m_t <= m_lat) m_busy = 1'b1;
      if (m_t == m_lat) begin
        m_done = 1'b1;
        m_out  = m_res;
      end
      if (m_t > m_lat) m_active = 1'b0;
    end
  endtask

  // One clock: inputs already set at negedge, model advances at posedge, compare at negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("out",  bus.out,          m_out);
    chk("busy", {31'h0, bus.busy}, {31'h0, m_busy});
    chk("done", {31'h0, bus.done}, {31'h0, m_done});
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input int k, input logic ar,
                        input logic hold_start, input logic [31:0] exp_out, input int exp_edges);
    int edges;
    int d0;
    bus.start = 1'b1;
    bus.in    = a;
    bus.shamt = SHAMT_W'(k);
    bus.arith = ar;
    d0 = done_cnt;
    tick();
    if (hold_start) bus.in = 32'hFFFF_FFFF;
    else            bus.start = 1'b0;
    edges = 0;
    while (bus.done !== 1'b1 && edges < 64) begin
      tick();
      edges++;
    end
    chk({name, "_edges"}, 32'(edges), 32'(exp_edges));
    chk({name, "_out"}, bus.out, exp_out);
    bus.start = 1'b0;
    tick();
    tick();
    chk({name, "_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.arith = 1'b0;
    bus.in    = 32'h0;
    bus.shamt = '0;
    tick();
    tick();
    chk("rst_out",  bus.out, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    reset = 1'b0;
    tick();

`ifdef SHIFT_RIGHT_FAST_EN
    run_op("srl4",  32'h8000_0000, 4, 1'b0, 1'b0, 32'h0800_0000, 1);
    run_op("sra31", 32'h8000_0000, 31, 1'b1, 1'b0, 32'hFFFF_FFFF, 10);
    run_op("srl31", 32'h8000_0000, 31, 1'b0, 1'b0, 32'h0000_0001, 10);
    run_op("hold8", 32'hF000_0000, 8, 1'b0, 1'b1, 32'h00F0_0000, 2);
`else
    run_op("srl4",  32'h8000_0000, 4, 1'b0, 1'b0, 32'h0800_0000, 4);
    run_op("sra31", 32'h8000_0000, 31, 1'b1, 1'b0, 32'hFFFF_FFFF, 31);
    run_op("srl31", 32'h8000_0000, 31, 1'b0, 1'b0, 32'h0000_0001, 31);
    run_op("hold8", 32'hF000_0000, 8, 1'b0, 1'b1, 32'h00F0_0000, 8);
`endif
    // Zero shift: done is already up right after the capture edge
    run_op("zero", 32'h1234_5678, 0, 1'b0, 1'b0, 32'h1234_5678, 0);
    run_op("sra5", 32'h8765_4321, 5, 1'b1, 1'b0, 32'hFC3B_2A19, latency(5));

    // Abort mid-shift
    bus.start = 1'b1;
    bus.in    = 32'hDEAD_BEEF;
    bus.shamt = SHAMT_W'(20);
    bus.arith = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    chk("abort_out",  bus.out, 32'h0);
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    reset = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 30; i++) tick();
    chk("abort_nodone", 32'(done_cnt - d0), 32'd0);

    // Random traffic, including start pulses while busy and sporadic resets
    for (int i = 0; i < 1500; i++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.in    = $urandom;
      bus.shamt = SHAMT_W'($urandom_range(0, WIDTH - 1));
      bus.arith = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
